// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard: ID-stage hazard detection, load-use/multi-cycle stalls and EX forwarding selects.
// Entries track stages 1 (EX) through NSTAGE (WB); rdy names the stage whose output carries the result.
module pipe_hazard_scoreboard #(
  parameter int AW       = 5,
  parameter int NSTAGE   = 3,
  parameter int LOAD_LAT = 1,
  parameter int MCYC_LAT = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [AW-1:0]             id_rs_i,
  input  logic [AW-1:0]             id_rt_i,
  input  logic                      id_rs_use_i,
  input  logic                      id_rt_use_i,
  input  logic [AW-1:0]             id_rd_i,
  input  logic                      id_wen_i,
  input  logic                      id_load_i,
  input  logic                      id_mcyc_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic                      bubble_o,
  output logic                      ex_hold_o,
  output logic [$clog2(NSTAGE)-1:0] fwd_a_o,
  output logic [$clog2(NSTAGE)-1:0] fwd_b_o,
  output logic [31:0]               stall_cnt_o
);
  localparam int FW = $clog2(NSTAGE);
  localparam int RW = $clog2(NSTAGE + 1);
  localparam int CW = $clog2(MCYC_LAT + 1);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          wen;
    logic [RW-1:0] rdy;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          rs_use;
    logic          rt_use;
    logic          mcyc;
  } entry_t;

  entry_t        st [1:NSTAGE];
  entry_t        id_e;
  logic [CW-1:0] cnt;
  logic          hazard;
  logic          mcyc_busy;
  logic          issue;

  function automatic logic prod(input entry_t e, input logic [AW-1:0] opr, input logic use_f);
    return use_f & e.valid & e.wen & (e.rd != '0) & (e.rd == opr);
  endfunction

  always_comb begin
    id_e = '{valid: 1'b1, rd: id_rd_i, wen: id_wen_i,
             rdy: id_load_i ? RW'(1 + LOAD_LAT) : RW'(1),
             rs: id_rs_i, rt: id_rt_i, rs_use: id_rs_use_i, rt_use: id_rt_use_i,
             mcyc: id_mcyc_i};
    hazard = 1'b0;
    // A producer still short of its rdy stage cannot be forwarded to the next EX cycle.
    for (int s = 1; s <= NSTAGE; s++)
      if (s + 1 <= int'(st[s].rdy) &&
          (prod(st[s], id_rs_i, id_rs_use_i) || prod(st[s], id_rt_i, id_rt_use_i)))
        hazard = 1'b1;
    hazard    = hazard & id_valid_i;
    mcyc_busy = st[1].valid & st[1].mcyc & (cnt != '0);
    stall_o   = mcyc_busy | (hazard & ~flush_i);
    ex_hold_o = mcyc_busy;
    issue     = id_valid_i & ~stall_o & ~flush_i;
    bubble_o  = ~mcyc_busy & ~issue;
  end

  always_comb begin
    fwd_a_o = '0;
    fwd_b_o = '0;
    // Descending scan so the youngest (smallest t) matching producer wins.
    for (int t = NSTAGE; t >= 2; t--) begin
      if (st[1].valid && t > int'(st[t].rdy) && prod(st[t], st[1].rs, st[1].rs_use))
        fwd_a_o = FW'(t - 1);
      if (st[1].valid && t > int'(st[t].rdy) && prod(st[t], st[1].rt, st[1].rt_use))
        fwd_b_o = FW'(t - 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 1; s <= NSTAGE; s++) st[s] <= '0;
      cnt         <= '0;
      stall_cnt_o <= '0;
    end else begin
      stall_cnt_o <= stall_cnt_o + 32'(stall_o);
      for (int s = 3; s <= NSTAGE; s++) st[s] <= st[s-1];
      st[2] <= mcyc_busy ? '0 : st[1];
      if (!mcyc_busy) st[1] <= issue ? id_e : '0;
      cnt <= issue ? (id_mcyc_i ? CW'(MCYC_LAT - 1) : '0) : (cnt != '0 ? cnt - 1'b1 : cnt);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb_pipe_hazard_scoreboard: directed scenarios plus random traffic checked against an in-bench pipeline model.
module tb_pipe_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0, id_rs_use = 1'b0, id_rt_use = 1'b0;
  logic        id_wen = 1'b0, id_load = 1'b0, id_mcyc = 1'b0, flush = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        stall, bubble, ex_hold;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt;
  logic        stall5, bubble5, ex_hold5;
  logic [2:0]  fwd_a5, fwd_b5;
  logic [31:0] stall_cnt5;
  int          errs = 0, checks = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_scoreboard dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_rs_use_i(id_rs_use), .id_rt_use_i(id_rt_use), .id_rd_i(id_rd), .id_wen_i(id_wen),
    .id_load_i(id_load), .id_mcyc_i(id_mcyc), .flush_i(flush), .stall_o(stall),
    .bubble_o(bubble), .ex_hold_o(ex_hold), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
    .stall_cnt_o(stall_cnt));

  pipe_hazard_scoreboard #(.NSTAGE(5), .LOAD_LAT(2)) dut5 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_rs_use_i(id_rs_use), .id_rt_use_i(id_rt_use), .id_rd_i(id_rd), .id_wen_i(id_wen),
    .id_load_i(id_load), .id_mcyc_i(id_mcyc), .flush_i(flush), .stall_o(stall5),
    .bubble_o(bubble5), .ex_hold_o(ex_hold5), .fwd_a_o(fwd_a5), .fwd_b_o(fwd_b5),
    .stall_cnt_o(stall_cnt5));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // Model: in-flight ops by stage (1=EX .. 3=WB), remaining multi-cycle busy cycles, stall total.
  typedef struct {bit v; int rd; bit wen; int rdy; int rs, rt; bit rsu, rtu, mc;} op_t;
  op_t m [1:3];
  int  mcnt = 0;
  int  mscnt = 0;

  function automatic bit m_prod(input op_t e, input int r);
    return e.v && e.wen && e.rd != 0 && e.rd == r;
  endfunction

  function automatic bit m_busy();
    return m[1].v && m[1].mc && mcnt > 0;
  endfunction

  function automatic bit m_stall();
    bit h = 0;
    for (int s = 1; s <= 3; s++)
      if (s + 1 <= m[s].rdy && ((id_rs_use && m_prod(m[s], int'(id_rs))) ||
                                (id_rt_use && m_prod(m[s], int'(id_rt)))))
        h = 1;
    return m_busy() || (id_valid && h && !flush);
  endfunction

  function automatic int m_fwd(input int r, input bit u);
    if (!m[1].v || !u) return 0;
    for (int t = 2; t <= 3; t++)
      if (m_prod(m[t], r) && t > m[t].rdy) return t - 1;
    return 0;
  endfunction

  always @(negedge clk) if (chk_en) begin
    bit st_e, is_e;
    st_e = m_stall();
    is_e = id_valid && !st_e && !flush;
    chk("model stall", stall, st_e);
    chk("model ex_hold", ex_hold, m_busy());
    chk("model bubble", bubble, !m_busy() && !is_e);
    chk("model fwd_a", fwd_a, m_fwd(m[1].rs, m[1].rsu));
    chk("model fwd_b", fwd_b, m_fwd(m[1].rt, m[1].rtu));
    chk("model stall_cnt", stall_cnt, mscnt);
  end

  always @(posedge clk) begin
    bit b, st_e, is_e;
    op_t n;
    b    = m_busy();
    st_e = m_stall();
    is_e = id_valid && !st_e && !flush;
    n    = '{1, int'(id_rd), id_wen, id_load ? 2 : 1, int'(id_rs), int'(id_rt),
             id_rs_use, id_rt_use, id_mcyc};
    if (rst) begin
      for (int s = 1; s <= 3; s++) m[s].v = 0;
      mcnt  = 0;
      mscnt = 0;
    end else begin
      mscnt += int'(st_e);
      m[3] = m[2];
      m[2] = m[1];
      if (b) m[2].v = 0;
      if (!b) begin
        m[1] = n;
        m[1].v = is_e;
      end
      mcnt = is_e ? (id_mcyc ? 3 : 0) : (mcnt > 0 ? mcnt - 1 : 0);
    end
  end

  task automatic drv(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                     input int rd, input bit wen, input bit ld, input bit mc, input bit fl);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_rs_use = rsu; id_rt_use = rtu;
    id_rd = 5'(rd); id_wen = wen; id_load = ld; id_mcyc = mc; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  initial begin
    gap(2);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst stall", stall, 0); chk("rst bubble", bubble, 1); chk("rst hold", ex_hold, 0);
    chk("rst fwd_a", fwd_a, 0); chk("rst fwd_b", fwd_b, 0); chk("rst cnt", stall_cnt, 0);
    chk("rst cnt5", stall_cnt5, 0);
    step();
    // Load r2 then add r3=r2+r4
    drv(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    @(negedge clk); chk("lu load stall", stall, 0);
    step();
    drv(1, 2, 4, 1, 1, 3, 1, 0, 0, 0);
    @(negedge clk); chk("lu stall", stall, 1); chk("lu bubble", bubble, 1); chk("lu stall5 a", stall5, 1);
    step();
    @(negedge clk); chk("lu issue stall", stall, 0); chk("lu issue bubble", bubble, 0); chk("lu stall5 b", stall5, 1);
    step();
    @(negedge clk); chk("lu fwd_a", fwd_a, 2); chk("lu fwd_b", fwd_b, 0); chk("lu cnt", stall_cnt, 1);
    chk("lu stall5 c", stall5, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("lu fwd_a5", fwd_a5, 3); chk("lu cnt5", stall_cnt5, 2);
    gap(4);
    // add r5; sub r6=r5-r5
    drv(1, 1, 1, 1, 1, 5, 1, 0, 0, 0);
    step();
    drv(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
    @(negedge clk); chk("b2b stall", stall, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("b2b fwd_a", fwd_a, 1); chk("b2b fwd_b", fwd_b, 1);
    gap(4);
    // r0 producer, then r7 with rt unused
    drv(1, 1, 1, 1, 1, 0, 1, 0, 0, 0);
    step();
    drv(1, 0, 0, 1, 1, 8, 1, 0, 0, 0);
    @(negedge clk); chk("r0 stall", stall, 0);
    step();
    drv(1, 1, 1, 1, 1, 7, 1, 0, 0, 0);
    @(negedge clk); chk("r0 fwd_a", fwd_a, 0); chk("r0 fwd_b", fwd_b, 0);
    step();
    drv(1, 7, 7, 1, 0, 9, 1, 0, 0, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rtu fwd_a", fwd_a, 1); chk("rtu fwd_b", fwd_b, 0);
    gap(4);
    // Multi-cycle op followed by an independent add
    drv(1, 1, 1, 1, 1, 8, 1, 0, 1, 0);
    step();
    drv(1, 1, 1, 1, 1, 9, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("mc stall", stall, 1); chk("mc hold", ex_hold, 1); chk("mc bubble", bubble, 0);
      step();
    end
    @(negedge clk); chk("mc issue stall", stall, 0); chk("mc issue hold", ex_hold, 0); chk("mc issue bubble", bubble, 0);
    gap(5);
    // Load-use hazard coinciding with flush
    drv(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    step();
    drv(1, 2, 4, 1, 1, 3, 1, 0, 0, 1);
    @(negedge clk); chk("fl stall", stall, 0); chk("fl bubble", bubble, 1);
    step();
    drv(1, 3, 3, 1, 1, 10, 1, 0, 0, 0);
    @(negedge clk); chk("fl consumer stall", stall, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("fl dropped fwd_a", fwd_a, 0); chk("fl dropped fwd_b", fwd_b, 0);
    gap(4);
    // Reset in the middle of a multi-cycle op
    drv(1, 1, 1, 1, 1, 8, 1, 0, 1, 0);
    step();
    gap(1);
    rst = 1'b1;
    @(negedge clk); chk("mrst busy before", ex_hold, 1);
    step();
    rst = 1'b0;
    drv(1, 1, 1, 1, 1, 4, 1, 0, 0, 0);
    @(negedge clk); chk("mrst stall", stall, 0); chk("mrst hold", ex_hold, 0); chk("mrst bubble", bubble, 0);
    chk("mrst fwd_a", fwd_a, 0); chk("mrst cnt", stall_cnt, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("mrst after hold", ex_hold, 0); chk("mrst after stall", stall, 0);
    gap(3);
    // Random traffic over a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drv($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
          $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 9) == 0);
      step();
    end
    rst = 1'b0;
    gap(4);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
